// File: rtl/sha256_digest_tx.sv
// Serialises one captured digest onto an 8-bit port, MSB byte first, one byte per host strobe edge.
// Latency: capture -> byte 0 next clk; strobe pin rise -> next byte SYNC_STAGES+2 clk later.
// Backpressure: digest_ready only in IDLE; the host paces bytes with rd_strobe, and no flag is raised if edges merge.
module sha256_digest_tx #(
   parameter int DIGEST_BITS = 256,
   parameter int SYNC_STAGES = 2,
   localparam int NBYTES = DIGEST_BITS / 8,
   localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ena,
   input  logic [DIGEST_BITS-1:0] digest_in,
   input  logic                   digest_valid,
   output logic                   digest_ready,
   input  logic                   rd_strobe,
   input  logic                   abort,
   output logic [7:0]             dout,
   output logic                   dout_valid,
   output logic [IDX_W-1:0]       byte_idx,
   output logic                   busy,
   output logic                   done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      FIN  = 2'd2
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

   state_t                 state_q, state_d;
   logic [DIGEST_BITS-1:0] shreg_q, shreg_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_d_q;
   logic                   edge_q;
   logic                   strobe_edge;

   // Synchroniser and edge history run regardless of ena so a stale level never looks like a new edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         s_d_q  <= 1'b0;
         edge_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rd_strobe};
         s_d_q  <= sync_q[SYNC_STAGES-1];
         edge_q <= sync_q[SYNC_STAGES-1] & ~s_d_q & ena;
      end
   end

   assign strobe_edge = edge_q & ena;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         shreg_q <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      idx_d   = idx_q;
      if (ena) begin
         if (abort) begin
            state_d = IDLE;
            shreg_d = '0;
            idx_d   = '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (digest_valid) begin
                     shreg_d = digest_in;
                     idx_d   = '0;
                     state_d = SEND;
                  end
               end
               SEND: begin
                  // The final byte is left in place so dout still shows it after the stream ends.
                  if (strobe_edge) begin
                     if (idx_q == LAST_IDX) begin
                        state_d = FIN;
                     end else begin
                        shreg_d = {shreg_q[DIGEST_BITS-9:0], 8'h00};
                        idx_d   = idx_q + IDX_W'(1);
                     end
                  end
               end
               FIN:     state_d = IDLE;
               default: state_d = IDLE;
            endcase
         end
      end
   end

   assign dout         = shreg_q[DIGEST_BITS-1 -: 8];
   assign byte_idx     = idx_q;
   assign digest_ready = (state_q == IDLE);
   assign busy         = (state_q == SEND);
   assign dout_valid   = (state_q == SEND);
   assign done         = (state_q == FIN);

endmodule
